// File: rtl/opb_register_pkg.sv
// Shared constants for the OPB register bank.
// Contents:
//   N_REGS_MAX      - largest legal number of user registers
//   CTRL_* indices  - bit positions inside the CTRL word
//   ctrl_offset()   - word offset of CTRL, which sits directly after the user registers
package opb_register_pkg;

   localparam int N_REGS_MAX      = 16;

   // The commit bit (write side) and the shadow-mode flag (read side) share bit 0.
   localparam int CTRL_COMMIT_BIT = 0;
   localparam int CTRL_SHADOW_BIT = 0;
   localparam int CTRL_DIRTY_BIT  = 1;

   function automatic logic [31:0] ctrl_offset(input int n_regs);
      return 32'(n_regs);
   endfunction

endpackage

// File: rtl/opb_be_merge.sv
// Byte-enable merge for one OPB write path.
// Ports:
//   old_i    - current 32-bit target value (bit 31 = MSB)
//   dbus_i   - OPB write data, ascending numbering (bit 0 = MSB)
//   be_i     - OPB byte enables, be_i[0] selects the most significant byte
//   merged_o - old_i with the enabled byte lanes replaced by write data
module opb_be_merge (
   input  logic [31:0] old_i,
   input  logic [0:31] dbus_i,
   input  logic [0:3]  be_i,
   output logic [31:0] merged_o
);

   logic [31:0] wdata;

   // Copying the ascending bus into a descending vector maps OPB bit 0 onto bit 31.
   assign wdata = dbus_i;

   always_comb begin
      merged_o = old_i;
      for (int j = 0; j < 4; j++) begin
         if (be_i[j]) begin
            merged_o[31-8*j -: 8] = wdata[31-8*j -: 8];
         end
      end
   end

endmodule

// File: rtl/opb_register_bank.sv
// OPB slave register bank with optional shadow-and-commit update.
// Ports:
//   OPB_Clk, OPB_Rst          - clock, synchronous active-high reset
//   OPB_ABus/BE/DBus/RNW/...  - OPB master request (OPB_seqAddr is not used)
//   Sl_DBus, Sl_xferAck       - registered read data and one-cycle acknowledge
//   Sl_errAck/retry/toutSup   - tied low
//   user_data_out             - register k on bits [32k+31:32k]
//   user_data_valid           - bit k pulses for one cycle when slice k changes
// Word map: 0..N_REGS-1 user registers, N_REGS = CTRL, anything else reads 0.
module opb_register_bank
   import opb_register_pkg::*;
#(
   parameter logic [31:0] C_BASEADDR   = 32'h0000_0000,
   parameter logic [31:0] C_HIGHADDR   = 32'h0000_FFFF,
   parameter int          C_OPB_AWIDTH = 32,
   parameter int          C_OPB_DWIDTH = 32,
   parameter              C_FAMILY     = "default",
   parameter int          N_REGS       = 4,
   parameter int          SHADOW_MODE  = 0
) (
   input  logic                   OPB_Clk,
   input  logic                   OPB_Rst,
   input  logic [0:31]            OPB_ABus,
   input  logic [0:3]             OPB_BE,
   input  logic [0:31]            OPB_DBus,
   input  logic                   OPB_RNW,
   input  logic                   OPB_select,
   input  logic                   OPB_seqAddr,
   output logic [0:31]            Sl_DBus,
   output logic                   Sl_xferAck,
   output logic                   Sl_errAck,
   output logic                   Sl_retry,
   output logic                   Sl_toutSup,
   output logic [N_REGS*32-1:0]   user_data_out,
   output logic [N_REGS-1:0]      user_data_valid
);

   if (N_REGS < 1 || N_REGS > N_REGS_MAX) begin : g_bad_n_regs
      $error("opb_register_bank: N_REGS out of range");
   end

   localparam logic SHADOW = (SHADOW_MODE != 0);

   logic [31:0]       out_q   [N_REGS];
   logic [31:0]       out_d   [N_REGS];
   logic [31:0]       shd_q   [N_REGS];
   logic [31:0]       shd_d   [N_REGS];
   logic [N_REGS-1:0] dirty_q, dirty_d;
   logic [N_REGS-1:0] valid_q, valid_d;
   logic              ack_q, ack_d;
   logic [31:0]       rdata_q, rdata_d;

   logic [31:0]       abus, offs, w;
   logic              match, accept, is_ctrl;
   logic [N_REGS-1:0] user_hit;
   logic [31:0]       old_val, ctrl_rd, merged;
   logic              unused_sig;

   assign abus    = OPB_ABus;
   assign offs    = abus - C_BASEADDR;
   assign w       = {2'b00, offs[31:2]};
   assign match   = (abus >= C_BASEADDR) && (abus <= C_HIGHADDR);
   // Blocking on ack_q keeps a held select from being accepted twice back to back.
   assign accept  = match && OPB_select && !ack_q;
   assign is_ctrl = (w == ctrl_offset(N_REGS));

   assign unused_sig = ^{OPB_seqAddr, offs[1:0]};

   // Value of the addressed user register as seen by the bus; 0 for non-user offsets,
   // which also makes CTRL writes merge against zero.
   always_comb begin
      old_val  = '0;
      user_hit = '0;
      for (int k = 0; k < N_REGS; k++) begin
         if (w == 32'(k)) begin
            user_hit[k] = 1'b1;
            old_val     = SHADOW ? shd_q[k] : out_q[k];
         end
      end
   end

   always_comb begin
      ctrl_rd                 = '0;
      ctrl_rd[CTRL_SHADOW_BIT] = SHADOW;
      ctrl_rd[CTRL_DIRTY_BIT]  = |dirty_q;
   end

   opb_be_merge u_be_merge (
      .old_i    (old_val),
      .dbus_i   (OPB_DBus),
      .be_i     (OPB_BE),
      .merged_o (merged)
   );

   always_comb begin
      out_d   = out_q;
      shd_d   = shd_q;
      dirty_d = dirty_q;
      valid_d = '0;
      ack_d   = accept;
      rdata_d = '0;
      if (accept) begin
         if (OPB_RNW) begin
            rdata_d = is_ctrl ? ctrl_rd : old_val;
         end else if (|OPB_BE) begin
            for (int k = 0; k < N_REGS; k++) begin
               if (user_hit[k]) begin
                  if (SHADOW) begin
                     shd_d[k]   = merged;
                     dirty_d[k] = 1'b1;
                  end else begin
                     out_d[k]   = merged;
                     valid_d[k] = 1'b1;
                  end
               end
            end
            // Clean shadows already equal their outputs, so copying all of them is safe.
            if (SHADOW && is_ctrl && merged[CTRL_COMMIT_BIT] && (|dirty_q)) begin
               for (int k = 0; k < N_REGS; k++) begin
                  out_d[k] = shd_q[k];
               end
               valid_d = dirty_q;
               dirty_d = '0;
            end
         end
      end
   end

   always_ff @(posedge OPB_Clk) begin
      if (OPB_Rst) begin
         for (int k = 0; k < N_REGS; k++) begin
            out_q[k] <= '0;
            shd_q[k] <= '0;
         end
         dirty_q <= '0;
         valid_q <= '0;
         ack_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         out_q   <= out_d;
         shd_q   <= shd_d;
         dirty_q <= dirty_d;
         valid_q <= valid_d;
         ack_q   <= ack_d;
         rdata_q <= rdata_d;
      end
   end

   for (genvar k = 0; k < N_REGS; k++) begin : g_out
      assign user_data_out[32*k +: 32] = out_q[k];
   end

   assign user_data_valid = valid_q;
   assign Sl_xferAck      = ack_q;
   assign Sl_DBus         = rdata_q;
   assign Sl_errAck       = 1'b0;
   assign Sl_retry        = 1'b0;
   assign Sl_toutSup      = 1'b0;

endmodule

// File: doc/opb_register_bank.md
OPB_REGISTER_BANK -- requirements
Module: opb_register_bank

Interface
REQ-001 SHALL have parameter C_BASEADDR, default 32'h00000000, base of the slave address window.
REQ-002 SHALL have parameter C_HIGHADDR, default 32'h0000FFFF, top of the slave address window (inclusive).
REQ-003 SHALL have parameters C_OPB_AWIDTH (default 32), C_OPB_DWIDTH (default 32) and C_FAMILY (default "default"), which are informational only.
REQ-004 SHALL have parameter N_REGS, default 4, number of user registers, legal range 1..16.
REQ-005 SHALL have parameter SHADOW_MODE, default 0; 0 = immediate update, 1 = shadow-and-commit.
REQ-006 SHALL have port OPB_Clk, input, 1 bit, the single clock for all logic.
REQ-007 SHALL have port OPB_Rst, input, 1 bit; reset is synchronous and active-high.
REQ-008 SHALL have port OPB_ABus, input, [0:31], address.
REQ-009 SHALL have port OPB_BE, input, [0:3], byte enables; bit 0 selects the most significant byte.
REQ-010 SHALL have port OPB_DBus, input, [0:31], write data; bit 0 is the MSB.
REQ-011 SHALL have ports OPB_RNW, OPB_select and OPB_seqAddr, each input, 1 bit; OPB_seqAddr is ignored.
REQ-012 SHALL have port Sl_DBus, output, [0:31], read data.
REQ-013 SHALL have port Sl_xferAck, output, 1 bit, transfer acknowledge.
REQ-014 SHALL have ports Sl_errAck, Sl_retry and Sl_toutSup, each output, 1 bit, each tied to 0.
REQ-015 SHALL have port user_data_out, output, [N_REGS*32-1:0]; register k occupies bits [32k+31:32k].
REQ-016 SHALL have port user_data_valid, output, [N_REGS-1:0]; bit k pulses for 1 cycle when slice k is updated.

Function
REQ-017 SHALL decode a match when C_BASEADDR <= OPB_ABus <= C_HIGHADDR; word offset w = (OPB_ABus - C_BASEADDR) >> 2.
REQ-018 SHALL map w = 0..N_REGS-1 to user register w, which is read/write.
REQ-019 SHALL map w = N_REGS to CTRL: a write with bit 0 = 1 commits; a read returns {30'b0, dirty, SHADOW_MODE}.
REQ-020 SHALL acknowledge every other matched offset, with reads returning 0 and writes ignored.
REQ-021 SHALL assert Sl_xferAck in the cycle after a sampled match && OPB_select && !Sl_xferAck, for exactly 1 cycle; it SHALL never be high in two consecutive cycles.
REQ-022 SHALL register read data together with Sl_xferAck, and SHALL drive Sl_DBus to 0 whenever Sl_xferAck is low.
REQ-023 SHALL, on a write, update only the byte lanes whose BE bit is 1, mapping OPB_DBus[0:7] to target bits [31:24] and so on down to [24:31] to [7:0].
REQ-024 SHALL, when SHADOW_MODE = 0, update user_data_out slice k and pulse user_data_valid[k] on the same edge that asserts Sl_xferAck; latency is 1 cycle from select.
REQ-025 SHALL, when SHADOW_MODE = 1, write only shadow[k] and set dirty[k]; user_data_out SHALL stay unchanged until a commit.
REQ-026 SHALL, on commit, copy every shadow register to user_data_out on the ack edge, pulse user_data_valid for each dirty bit, and clear all dirty bits.
REQ-027 SHALL treat a commit with no dirty bits as a no-op with no valid pulse; a CTRL write with bit 0 = 0 SHALL have no effect.
REQ-028 SHALL return the shadow value on a read of register k when SHADOW_MODE = 1, and the output value otherwise.
REQ-029 SHALL ignore commit writes when SHADOW_MODE = 0, and the dirty read-back SHALL then be 0.
REQ-030 SHALL not alter any state on a write with BE = 4'b0000, but SHALL still acknowledge it.

Reset
REQ-031 SHALL, while OPB_Rst = 1, clear Sl_xferAck, user_data_out, user_data_valid, all shadows and all dirty bits to 0 on the next edge.
REQ-032 SHALL, if reset lands on a pending transfer, drop that transfer without acknowledging it; the master re-issues after reset.

Structure
REQ-033 SHALL place the CTRL offset function, CTRL bit indices and the N_REGS limit in the shared package opb_register_pkg.
REQ-034 SHALL implement the byte-lane swap and BE merge in one sub-module, opb_be_merge, instanced once per write path.

Verification
REQ-035 SHALL verify: SHADOW_MODE=0, write 32'hDEADBEEF with BE=1111 to offset 0x4 -> slice 1 = 32'hDEADBEEF, valid = 4'b0010 for 1 cycle, ack 1 cycle after select.
REQ-036 SHALL verify: write 32'h11223344 with BE=0101 over 32'hAABBCCDD -> 32'hAA22CC44; a read-back returns 32'hAA22CC44 on Sl_DBus only during ack.
REQ-037 SHALL verify: SHADOW_MODE=1, write regs 0 and 2 -> outputs unchanged and CTRL reads 0x3; a commit then gives valid = 4'b0101 and CTRL reads 0x1.
REQ-038 SHALL verify: an out-of-range offset 0x40 read -> ack with 0; a write is ignored; a select held 4 cycles -> acks in cycles 2 and 4 only.
REQ-039 SHALL verify: OPB_Rst asserted in the select cycle -> no ack, and all outputs are 0 on the next edge.
